pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter sequencer for the 8-bit CPU.
- Sits directly upstream of the 16-bit address register and drives that register's IN/LOAD pair through ADDR_OUT/ADDR_LOAD.
- Holds the architectural PC and applies increment, absolute jump, signed relative branch, call and return.
- Return addresses live in a small internal LIFO.

Parameters:
- RESET_VECTOR, 16'h0000, PC and ADDR_OUT value after reset.
- STACK_DEPTH, 4, number of return-address entries; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset; RESET=0 clears all state immediately.
- OP  input  3  000 NOP, 001 INC, 010 JMP, 011 BRR, 100 CALL, 101 RET, 110/111 reserved (treated as NOP).
- OP_VALID  input  1  OP/TARGET/REL are sampled this cycle.
- STALL  input  1  freeze; dominates OP_VALID.
- TARGET  input  16  absolute address for JMP/CALL.
- REL  input  8  signed two's-complement offset for BRR.
- ADDR_OUT  output  16  registered next address; wires to the address register IN.
- ADDR_LOAD  output  1  registered one-cycle strobe; wires to the address register LOAD.
- PC  output  16  current internal PC.
- DEPTH  output  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
- STK_ERR  output  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset (RESET=0, asynchronous):
  - PC=RESET_VECTOR, ADDR_OUT=RESET_VECTOR.
  - ADDR_LOAD=0, DEPTH=0, STK_ERR=0.
  - Stack contents are don't-care.
  - Asserting RESET mid-operation aborts any in-flight op; no partial push or pop survives.
- Accept condition: an op is accepted on a rising edge when RESET=1, OP_VALID=1, STALL=0 and the op is legal.
- On acceptance, at the same edge:
  - PC <= NPC, ADDR_OUT <= NPC, ADDR_LOAD <= 1.
  - Latency is one clock from sampled op to new ADDR_OUT.
  - The address register captures it on the following edge.
- Any edge without an accepted op:
  - ADDR_LOAD <= 0; PC and ADDR_OUT hold.
  - ADDR_LOAD is therefore never high for two consecutive cycles unless ops are accepted back-to-back.
- NPC per op (all arithmetic modulo 2^16, silent wrap):
  - INC: PC+1; 16'hFFFF wraps to 16'h0000.
  - JMP: TARGET.
  - BRR: PC + sign-extended REL. REL=8'h80 gives PC-128, REL=8'h7F gives PC+127.
  - CALL: push (PC+1) mod 2^16 to stack[DEPTH], DEPTH++, NPC=TARGET.
  - RET: DEPTH--, NPC=stack[DEPTH-1].
  - NOP/reserved: not accepted; ADDR_LOAD=0, no state change.
- Stack boundaries:
  - CALL with DEPTH==STACK_DEPTH is an overflow: no push, no PC change, ADDR_LOAD=0, STK_ERR<=1.
  - RET with DEPTH==0 is an underflow: no pop, no PC change, ADDR_LOAD=0, STK_ERR<=1.
  - STK_ERR clears only on reset.
  - Pushing to the final free slot and popping from the last entry are both legal.
- STALL=1:
  - OP_VALID is ignored and the op is dropped, not queued.
  - The upstream controller holds OP_VALID until STALL falls.
- Control is purely cycle-based; there is no multi-cycle FSM.
- The stack is a register array indexed by DEPTH, written only on an accepted CALL.

Test Plan:
- Reset then 3 consecutive INC (RESET_VECTOR=0) -> ADDR_OUT 0001, 0002, 0003 on successive cycles; ADDR_LOAD high 3 cycles then low; PC=0003.
- JMP TARGET=FFFE, then INC, INC -> ADDR_OUT FFFE, FFFF, 0000; no error.
- PC=0100: BRR REL=80 -> 0080; then BRR REL=7F -> 00FF.
- PC=1000: CALL TARGET=2000, CALL TARGET=3000, then RET, RET:
  - ADDR_OUT sequence 2000, 3000, 2001, 1001.
  - DEPTH sequence 1, 2, 1, 0.
- Stack errors:
  - 5 CALLs with STACK_DEPTH=4 -> 5th leaves PC unchanged, ADDR_LOAD=0, STK_ERR=1, DEPTH=4.
  - Separately, RET at DEPTH=0 -> STK_ERR=1, PC unchanged.
- STALL=1 with OP_VALID=1, OP=INC for 2 cycles -> no ADDR_LOAD, PC unchanged.
- RESET pulsed low asynchronously mid-CALL (between edges) -> PC=RESET_VECTOR, DEPTH=0, STK_ERR=0, ADDR_LOAD=0 immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, applies INC/JMP/BRR/CALL/RET and
// drives a registered address plus one-cycle load strobe to the address register.
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int          STACK_DEPTH  = 4
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic [2:0]                         OP,
    input  logic                               OP_VALID,
    input  logic                               STALL,
    input  logic [15:0]                        TARGET,
    input  logic [7:0]                         REL,
    output logic [15:0]                        ADDR_OUT,
    output logic                               ADDR_LOAD,
    output logic [15:0]                        PC,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   DEPTH,
    output logic                               STK_ERR
);

    localparam int DW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_INC  = 3'b001,
        OP_JMP  = 3'b010,
        OP_BRR  = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } op_e;

    logic [15:0]   pc_q, pc_d;
    logic [15:0]   addr_q, addr_d;
    logic          load_q, load_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic [15:0]   stack_q [STACK_DEPTH];
    logic [15:0]   stack_d [STACK_DEPTH];

    logic [15:0]   pc_inc;
    logic [15:0]   rel_ext;
    logic [15:0]   stack_top;
    logic          take;
    logic          accept;
    logic          push;
    logic [15:0]   npc;

    assign pc_inc  = pc_q + 16'd1;
    assign rel_ext = {{8{REL[7]}}, REL};
    assign take    = OP_VALID && !STALL;

    // Entry just below the current depth is the return address for RET.
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) stack_top = stack_q[i];
        end
    end

    always_comb begin
        accept  = 1'b0;
        push    = 1'b0;
        npc     = pc_q;
        depth_d = depth_q;
        err_d   = err_q;
        if (take) begin
            case (op_e'(OP))
                OP_INC: begin
                    accept = 1'b1;
                    npc    = pc_inc;
                end
                OP_JMP: begin
                    accept = 1'b1;
                    npc    = TARGET;
                end
                OP_BRR: begin
                    accept = 1'b1;
                    npc    = pc_q + rel_ext;
                end
                OP_CALL: begin
                    if (depth_q == DW'(STACK_DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        push    = 1'b1;
                        depth_d = depth_q + DW'(1);
                        npc     = TARGET;
                    end
                end
                OP_RET: begin
                    if (depth_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        depth_d = depth_q - DW'(1);
                        npc     = stack_top;
                    end
                end
                default: ;
            endcase
        end
        pc_d   = accept ? npc : pc_q;
        addr_d = accept ? npc : addr_q;
        load_d = accept;
    end

    always_comb begin
        stack_d = stack_q;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && depth_q == DW'(i)) stack_d[i] = pc_inc;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q    <= RESET_VECTOR;
            addr_q  <= RESET_VECTOR;
            load_q  <= 1'b0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            load_q  <= load_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack contents are don't-care after reset since DEPTH returns to zero.
    always_ff @(posedge CLK) begin
        stack_q <= stack_d;
    end

    assign ADDR_OUT  = addr_q;
    assign ADDR_LOAD = load_q;
    assign PC        = pc_q;
    assign DEPTH     = depth_q;
    assign STK_ERR   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected loads, a monitor
// pops them whenever ADDR_LOAD is seen; status outputs are checked directly.
module tb_pc_sequencer;

    localparam int DW = $clog2(4 + 1);

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic [2:0]    OP = 3'b000;
    logic          OP_VALID = 1'b0;
    logic          STALL = 1'b0;
    logic [15:0]   TARGET = '0;
    logic [7:0]    REL = '0;
    logic [15:0]   ADDR_OUT;
    logic          ADDR_LOAD;
    logic [15:0]   PC;
    logic [DW-1:0] DEPTH;
    logic          STK_ERR;

    pc_sequencer #(.RESET_VECTOR(16'h0000), .STACK_DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .OP(OP), .OP_VALID(OP_VALID), .STALL(STALL),
        .TARGET(TARGET), .REL(REL), .ADDR_OUT(ADDR_OUT), .ADDR_LOAD(ADDR_LOAD),
        .PC(PC), .DEPTH(DEPTH), .STK_ERR(STK_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0]   addr;
        logic [DW-1:0] depth;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [2:0] NOP = 3'b000, INC = 3'b001, JMP = 3'b010,
                           BRR = 3'b011, CALL = 3'b100, RET = 3'b101;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic expect_load(input logic [15:0] addr, input logic [DW-1:0] depth);
        exp_t e;
        e.addr  = addr;
        e.depth = depth;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] o, input logic [15:0] t, input logic [7:0] r);
        @(negedge CLK);
        OP = o; TARGET = t; REL = r; OP_VALID = 1'b1; STALL = 1'b0;
        @(posedge CLK);
        #2;
    endtask

    task automatic idle();
        @(negedge CLK);
        OP_VALID = 1'b0; STALL = 1'b0; OP = NOP;
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        OP_VALID = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    // Monitor: every load strobe must match the oldest expectation.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (ADDR_LOAD === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_load: got addr %h depth %0d, expected no load", ADDR_OUT, DEPTH);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (ADDR_OUT !== e.addr || PC !== e.addr || DEPTH !== e.depth) begin
                        miscompares++;
                        $display("FAIL load: got addr %h pc %h depth %0d expected addr/pc %h depth %0d",
                                 ADDR_OUT, PC, DEPTH, e.addr, e.depth);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        #3;
        check("rst_pc", PC, 16'h0000);
        check("rst_addr", ADDR_OUT, 16'h0000);
        check("rst_load", 16'(ADDR_LOAD), 16'h0);
        check("rst_depth", 16'(DEPTH), 16'h0);
        check("rst_err", 16'(STK_ERR), 16'h0);
        @(negedge CLK);
        RESET = 1'b1;

        // Three consecutive INC
        expect_load(16'h0001, 0); issue(INC, 16'h0, 8'h0);
        expect_load(16'h0002, 0); issue(INC, 16'h0, 8'h0);
        expect_load(16'h0003, 0); issue(INC, 16'h0, 8'h0);
        idle();
        check("inc_load_low", 16'(ADDR_LOAD), 16'h0);
        check("inc_pc", PC, 16'h0003);

        // JMP near the top, then wrap on INC
        expect_load(16'hFFFE, 0); issue(JMP, 16'hFFFE, 8'h0);
        expect_load(16'hFFFF, 0); issue(INC, 16'h0, 8'h0);
        expect_load(16'h0000, 0); issue(INC, 16'h0, 8'h0);
        idle();
        check("wrap_err", 16'(STK_ERR), 16'h0);

        // Relative branch extremes
        expect_load(16'h0100, 0); issue(JMP, 16'h0100, 8'h0);
        expect_load(16'h0080, 0); issue(BRR, 16'h0, 8'h80);
        expect_load(16'h00FF, 0); issue(BRR, 16'h0, 8'h7F);
        idle();

        // Nested CALL/RET
        expect_load(16'h1000, 0); issue(JMP, 16'h1000, 8'h0);
        expect_load(16'h2000, 1); issue(CALL, 16'h2000, 8'h0);
        expect_load(16'h3000, 2); issue(CALL, 16'h3000, 8'h0);
        expect_load(16'h2001, 1); issue(RET, 16'h0, 8'h0);
        expect_load(16'h1001, 0); issue(RET, 16'h0, 8'h0);
        idle();
        check("call_err", 16'(STK_ERR), 16'h0);

        // STALL dominates OP_VALID for two cycles
        @(negedge CLK);
        OP = INC; OP_VALID = 1'b1; STALL = 1'b1;
        @(posedge CLK); #2;
        check("stall1_load", 16'(ADDR_LOAD), 16'h0);
        @(posedge CLK); #2;
        check("stall2_load", 16'(ADDR_LOAD), 16'h0);
        check("stall_pc", PC, 16'h1001);
        idle();

        // Underflow
        issue(RET, 16'h0, 8'h0);
        check("under_load", 16'(ADDR_LOAD), 16'h0);
        check("under_err", 16'(STK_ERR), 16'h1);
        check("under_pc", PC, 16'h1001);
        idle();
        check("under_sticky", 16'(STK_ERR), 16'h1);

        // Overflow after filling all four slots, then drain to empty
        do_reset();
        check("rst2_err", 16'(STK_ERR), 16'h0);
        expect_load(16'h0010, 1); issue(CALL, 16'h0010, 8'h0);
        expect_load(16'h0020, 2); issue(CALL, 16'h0020, 8'h0);
        expect_load(16'h0030, 3); issue(CALL, 16'h0030, 8'h0);
        expect_load(16'h0040, 4); issue(CALL, 16'h0040, 8'h0);
        issue(CALL, 16'h0050, 8'h0);
        check("over_load", 16'(ADDR_LOAD), 16'h0);
        check("over_pc", PC, 16'h0040);
        check("over_depth", 16'(DEPTH), 16'h4);
        check("over_err", 16'(STK_ERR), 16'h1);
        expect_load(16'h0031, 3); issue(RET, 16'h0, 8'h0);
        expect_load(16'h0021, 2); issue(RET, 16'h0, 8'h0);
        expect_load(16'h0011, 1); issue(RET, 16'h0, 8'h0);
        expect_load(16'h0001, 0); issue(RET, 16'h0, 8'h0);
        idle();

        // Reserved opcode is a no-op
        issue(3'b110, 16'h1234, 8'h12);
        check("rsvd_load", 16'(ADDR_LOAD), 16'h0);
        check("rsvd_pc", PC, 16'h0001);
        idle();

        // Asynchronous reset between edges during a CALL
        expect_load(16'h0600, 1); issue(CALL, 16'h0600, 8'h0);
        @(negedge CLK);
        OP = CALL; TARGET = 16'h0700; OP_VALID = 1'b1;
        #2;
        RESET = 1'b0;
        #1;
        check("arst_pc", PC, 16'h0000);
        check("arst_depth", 16'(DEPTH), 16'h0);
        check("arst_err", 16'(STK_ERR), 16'h0);
        check("arst_load", 16'(ADDR_LOAD), 16'h0);
        @(posedge CLK); #2;
        check("arst_hold_depth", 16'(DEPTH), 16'h0);
        @(negedge CLK);
        OP_VALID = 1'b0;
        RESET = 1'b1;
        expect_load(16'h0001, 0); issue(INC, 16'h0, 8'h0);
        idle();
        idle();

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_loads: got %0d outstanding expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
